// File: rtl/psk_pulse_sequencer.sv
// PSK burst sequencer: pulse/gap timebase in microseconds and
// per-chip 0/180 phase-code select for the phase accumulator.
module psk_pulse_sequencer #(
  parameter int CLK_PER_US = 500,
  parameter int CODE_W     = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SIGN_START_GEN,
  input  logic              ABORT,
  input  logic [9:0]        T_IMPULSE,
  input  logic [12:0]       T_PERIOD,
  input  logic [4:0]        NUM_OF_IMP,
  input  logic [CODE_W-1:0] PSK_CODE,
  input  logic [4:0]        CODE_LEN,
  input  logic [15:0]       T_CHIP,
  output logic              SIGN_START_CALC,
  output logic              SIGN_STOP_CALC,
  output logic              GEN_ACTIVE,
  output logic              PHASE_FLIP,
  output logic [4:0]        IMP_INDEX,
  output logic              BUSY,
  output logic              DONE,
  output logic              CFG_ERR
);
  localparam int PW = $clog2(CLK_PER_US);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_US - 1);
  localparam int LEN_MAX = (CODE_W < 32) ? CODE_W - 1 : 31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } state_t;

  state_t            r_state;
  logic              r_start_d;
  logic [PW-1:0]     r_pre;
  logic [12:0]       r_us;
  logic [15:0]       r_chip_cnt;
  logic [4:0]        r_chip_idx;
  logic [9:0]        r_t_imp;
  logic [12:0]       r_t_per;
  logic [4:0]        r_num;
  logic [CODE_W-1:0] r_code;
  logic [4:0]        r_len;
  logic [15:0]       r_t_chip;
  logic              r_start_calc;
  logic              r_stop_calc;
  logic              r_gen;
  logic              r_phase;
  logic [4:0]        r_imp_idx;
  logic              r_busy;
  logic              r_done;
  logic              r_cfg_err;

  logic          w_edge;
  logic          w_cfg_ok;
  logic [4:0]    w_len_in;
  logic          w_pre_wrap;
  logic [PW-1:0] w_pre_nxt;
  logic [12:0]   w_us_inc;
  logic [12:0]   w_us_nxt;
  logic          w_imp_end;
  logic          w_per_end;
  logic          w_chip_wrap;
  logic [15:0]   w_chip_cnt_nxt;
  logic [4:0]    w_idx_nxt;
  logic          w_last;

  assign w_edge   = SIGN_START_GEN & ~r_start_d;
  assign w_cfg_ok = (NUM_OF_IMP != 5'd0) && (T_IMPULSE != 10'd0) &&
                    (T_CHIP != 16'd0) && (T_PERIOD > {3'd0, T_IMPULSE});
  assign w_len_in = (int'(CODE_LEN) > LEN_MAX) ? 5'(LEN_MAX) : CODE_LEN;

  assign w_pre_wrap = (r_pre == PRE_MAX);
  assign w_pre_nxt  = w_pre_wrap ? '0 : r_pre + PW'(1);
  assign w_us_inc   = r_us + 13'd1;
  assign w_us_nxt   = w_pre_wrap ? w_us_inc : r_us;
  assign w_imp_end  = w_pre_wrap && (w_us_inc == {3'd0, r_t_imp});
  assign w_per_end  = w_pre_wrap && (w_us_inc == r_t_per);

  assign w_chip_wrap    = (r_chip_cnt == r_t_chip - 16'd1);
  assign w_chip_cnt_nxt = w_chip_wrap ? 16'd0 : r_chip_cnt + 16'd1;
  assign w_idx_nxt      = !w_chip_wrap            ? r_chip_idx :
                          (r_chip_idx == r_len)   ? 5'd0 :
                                                    r_chip_idx + 5'd1;
  assign w_last = (r_imp_idx == r_num - 5'd1);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= S_IDLE;
      r_start_d    <= 1'b0;
      r_pre        <= '0;
      r_us         <= '0;
      r_chip_cnt   <= '0;
      r_chip_idx   <= '0;
      r_t_imp      <= '0;
      r_t_per      <= '0;
      r_num        <= '0;
      r_code       <= '0;
      r_len        <= '0;
      r_t_chip     <= '0;
      r_start_calc <= 1'b0;
      r_stop_calc  <= 1'b0;
      r_gen        <= 1'b0;
      r_phase      <= 1'b0;
      r_imp_idx    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_start_d    <= SIGN_START_GEN;
      r_start_calc <= 1'b0;
      r_stop_calc  <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_edge && w_cfg_ok) begin
            r_t_imp      <= T_IMPULSE;
            r_t_per      <= T_PERIOD;
            r_num        <= NUM_OF_IMP;
            r_code       <= PSK_CODE;
            r_len        <= w_len_in;
            r_t_chip     <= T_CHIP;
            r_state      <= S_PULSE;
            r_pre        <= '0;
            r_us         <= '0;
            r_chip_cnt   <= '0;
            r_chip_idx   <= '0;
            r_imp_idx    <= '0;
            r_start_calc <= 1'b1;
            r_gen        <= 1'b1;
            r_phase      <= PSK_CODE[0];
            r_busy       <= 1'b1;
          end else if (w_edge) begin
            r_cfg_err <= 1'b1;
          end
        end
        S_PULSE: begin
          if (ABORT) begin
            r_state     <= S_IDLE;
            r_stop_calc <= 1'b1;
            r_gen       <= 1'b0;
            r_phase     <= 1'b0;
            r_busy      <= 1'b0;
            r_imp_idx   <= '0;
          end else begin
            r_pre      <= w_pre_nxt;
            r_us       <= w_us_nxt;
            r_chip_cnt <= w_chip_cnt_nxt;
            r_chip_idx <= w_idx_nxt;
            if (w_imp_end) begin
              r_state     <= S_GAP;
              r_stop_calc <= 1'b1;
              r_gen       <= 1'b0;
              r_phase     <= 1'b0;
            end else begin
              r_phase <= r_code[w_idx_nxt];
            end
          end
        end
        S_GAP: begin
          if (ABORT || (w_per_end && w_last)) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_imp_idx <= '0;
            r_done    <= ~ABORT;
          end else if (w_per_end) begin
            r_state      <= S_PULSE;
            r_pre        <= '0;
            r_us         <= '0;
            r_chip_cnt   <= '0;
            r_chip_idx   <= '0;
            r_imp_idx    <= r_imp_idx + 5'd1;
            r_start_calc <= 1'b1;
            r_gen        <= 1'b1;
            r_phase      <= r_code[0];
          end else begin
            r_pre <= w_pre_nxt;
            r_us  <= w_us_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SIGN_START_CALC = r_start_calc;
  assign SIGN_STOP_CALC  = r_stop_calc;
  assign GEN_ACTIVE      = r_gen;
  assign PHASE_FLIP      = r_phase;
  assign IMP_INDEX       = r_imp_idx;
  assign BUSY            = r_busy;
  assign DONE            = r_done;
  assign CFG_ERR         = r_cfg_err;

endmodule

// File: tb/tb_psk_pulse_sequencer.sv
// Bench for psk_pulse_sequencer: cycle-offset burst model plus
// directed literal checks.
module tb_psk_pulse_sequencer;
  localparam int C = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        s_start = 1'b0;
  logic        s_abort = 1'b0;
  logic [9:0]  s_timp = '0;
  logic [12:0] s_tper = '0;
  logic [4:0]  s_num = '0;
  logic [31:0] s_code = '0;
  logic [4:0]  s_len = '0;
  logic [15:0] s_tchip = '0;

  logic       o_start, o_stop, o_gen, o_phase, o_busy, o_done, o_err;
  logic [4:0] o_idx;

  int checks = 0;
  int failures = 0;

  psk_pulse_sequencer #(.CLK_PER_US(C), .CODE_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .SIGN_START_GEN(s_start), .ABORT(s_abort),
    .T_IMPULSE(s_timp), .T_PERIOD(s_tper), .NUM_OF_IMP(s_num),
    .PSK_CODE(s_code), .CODE_LEN(s_len), .T_CHIP(s_tchip),
    .SIGN_START_CALC(o_start), .SIGN_STOP_CALC(o_stop),
    .GEN_ACTIVE(o_gen), .PHASE_FLIP(o_phase), .IMP_INDEX(o_idx),
    .BUSY(o_busy), .DONE(o_done), .CFG_ERR(o_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, act, exp);
    end
  endtask

  // Burst model: expectations follow from the offset of the cycle
  // from the first pulse start of the accepted burst.
  int   m_t = 0, m_base = 0, m_stop_at = -1, m_err_at = -1;
  bit   m_active = 0, m_prev = 0;
  int   m_timp, m_tper, m_num, m_tchip, m_len;
  logic [31:0] m_code;
  bit   e_start = 0, e_stop = 0, e_gen = 0, e_phase = 0;
  bit   e_busy = 0, e_done = 0, e_err = 0;
  int   e_idx = 0;

  initial forever begin
    @(posedge CLK or negedge RESET);
    if (!RESET) begin
      m_active = 0; m_prev = 0; m_stop_at = -1; m_err_at = -1;
      e_start = 0; e_stop = 0; e_gen = 0; e_phase = 0;
      e_busy = 0; e_done = 0; e_err = 0; e_idx = 0;
    end else begin : step
      int  off, per, w;
      bit  edge_s, idle, in_pulse;
      edge_s = s_start && !m_prev;
      m_prev = s_start;
      idle = 1; in_pulse = 0;
      if (m_active) begin
        per = m_tper * C;
        off = m_t - m_base;
        if (off < m_num * per) begin
          idle = 0;
          in_pulse = (off % per) < m_timp * C;
        end
      end
      if (!idle && s_abort) begin
        if (in_pulse) m_stop_at = m_t + 1;
        m_active = 0;
      end else if (idle && edge_s) begin
        if (s_num != 0 && s_timp != 0 && s_tchip != 0 &&
            int'(s_tper) > int'(s_timp)) begin
          m_active = 1; m_base = m_t + 1;
          m_timp = s_timp; m_tper = s_tper; m_num = s_num;
          m_tchip = s_tchip; m_code = s_code;
          m_len = (s_len > 31) ? 31 : int'(s_len);
        end else begin
          m_err_at = m_t + 1;
        end
      end
      m_t++;
      e_start = 0; e_stop = 0; e_gen = 0; e_phase = 0;
      e_busy = 0; e_done = 0; e_err = 0; e_idx = 0;
      if (m_active) begin
        per = m_tper * C;
        off = m_t - m_base;
        if (off < m_num * per) begin
          w = off % per;
          e_busy  = 1;
          e_idx   = off / per;
          e_start = (w == 0);
          e_gen   = (w < m_timp * C);
          e_stop  = (w == m_timp * C);
          e_phase = e_gen && m_code[(w / m_tchip) % (m_len + 1)];
        end else begin
          if (off == m_num * per) e_done = 1;
          m_active = 0;
        end
      end
      if (m_stop_at == m_t) e_stop = 1;
      if (m_err_at == m_t) e_err = 1;
    end
  end

  initial forever begin
    @(negedge CLK);
    chk("start_calc", o_start, e_start);
    chk("stop_calc",  o_stop,  e_stop);
    chk("gen_active", o_gen,   e_gen);
    chk("phase_flip", o_phase, e_phase);
    chk("imp_index",  o_idx,   e_idx);
    chk("busy",       o_busy,  e_busy);
    chk("done",       o_done,  e_done);
    chk("cfg_err",    o_err,   e_err);
  end

  task automatic go(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic cfg(input int timp, input int tper, input int num,
                     input int tchip, input logic [31:0] code,
                     input int len);
    s_timp = 10'(timp); s_tper = 13'(tper); s_num = 5'(num);
    s_tchip = 16'(tchip); s_code = code; s_len = 5'(len);
  endtask

  // Raises the start input for one cycle; returns at cycle k+1.
  task automatic start_burst();
    s_start = 1'b1;
    go(1);
    s_start = 1'b0;
  endtask

  bit exp_ph [12];
  int bad_timp [5];
  int bad_tper [5];
  int bad_num  [5];
  int bad_tch  [5];

  initial begin
    exp_ph   = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    bad_timp = '{10, 2, 0, 2, 5};
    bad_tper = '{2,  5, 5, 5, 5};
    bad_num  = '{3,  0, 3, 3, 3};
    bad_tch  = '{3,  3, 3, 0, 3};

    cfg(2, 5, 3, 3, 32'hA5, 4);
    go(3);
    chk("rst_start", o_start, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_gen", o_gen, 0);
    RESET = 1'b1;
    go(2);

    // basic three-pulse burst
    start_burst();
    chk("t1_start0", o_start, 1);
    chk("t1_idx0", o_idx, 0);
    go(7);
    chk("t1_gen_s7", o_gen, 1);
    go(1);
    chk("t1_stop_s8", o_stop, 1);
    chk("t1_gen_s8", o_gen, 0);
    go(12);
    chk("t1_start_s20", o_start, 1);
    chk("t1_idx1", o_idx, 1);
    go(20);
    chk("t1_start_s40", o_start, 1);
    chk("t1_idx2", o_idx, 2);
    go(8);
    chk("t1_stop_s48", o_stop, 1);
    go(11);
    chk("t1_busy_s59", o_busy, 1);
    go(1);
    chk("t1_done_s60", o_done, 1);
    chk("t1_busy_s60", o_busy, 0);
    go(3);

    // phase code with wrap after CODE_LEN
    cfg(3, 5, 2, 2, 32'b1011, 3);
    start_burst();
    for (int i = 0; i < 12; i++) begin
      chk("t2_phase_p0", o_phase, exp_ph[i]);
      go(1);
    end
    chk("t2_phase_off", o_phase, 0);
    go(8);
    for (int i = 0; i < 6; i++) begin
      chk("t2_phase_p1", o_phase, exp_ph[i]);
      go(1);
    end
    go(23);

    // rejected configurations
    for (int i = 0; i < 5; i++) begin
      cfg(bad_timp[i], bad_tper[i], bad_num[i], bad_tch[i], 32'h1, 2);
      start_burst();
      chk("t3_cfg_err", o_err, 1);
      chk("t3_no_start", o_start, 0);
      chk("t3_no_busy", o_busy, 0);
      go(1);
      chk("t3_err_clr", o_err, 0);
      go(1);
    end

    // abort in pulse, then abort with start in idle, abort in gap
    cfg(2, 5, 3, 3, 32'h6, 2);
    start_burst();
    go(22);
    chk("t4_gen_s22", o_gen, 1);
    s_abort = 1'b1;
    go(1);
    s_abort = 1'b0;
    chk("t4_ab_stop", o_stop, 1);
    chk("t4_ab_gen", o_gen, 0);
    chk("t4_ab_busy", o_busy, 0);
    chk("t4_ab_done", o_done, 0);
    go(60);
    s_abort = 1'b1;
    start_burst();
    s_abort = 1'b0;
    chk("t4_restart", o_start, 1);
    go(11);
    s_abort = 1'b1;
    go(1);
    s_abort = 1'b0;
    chk("t4_gap_busy", o_busy, 0);
    chk("t4_gap_stop", o_stop, 0);
    go(5);

    // start toggling and config changes during a burst
    cfg(2, 5, 3, 3, 32'h3, 1);
    start_burst();
    for (int j = 1; j <= 60; j++) begin
      go(1);
      if (j < 60) s_start = ((j / 5) % 2 == 0);
      if (j == 3) s_timp = 10'd1;
      if (j == 7) chk("t5_gen_s7", o_gen, 1);
      if (j == 8) chk("t5_stop_s8", o_stop, 1);
      if (j == 28) chk("t5_stop_s28", o_stop, 1);
      if (j == 60) begin
        chk("t5_done", o_done, 1);
        s_start = 1'b1;
      end
    end
    go(1);
    s_start = 1'b0;
    chk("t5_rearm", o_start, 1);
    chk("t5_rearm_idx", o_idx, 0);
    go(65);

    // asynchronous reset mid-pulse
    cfg(2, 5, 3, 3, 32'hF, 3);
    start_burst();
    go(3);
    RESET = 1'b0;
    #1;
    chk("t6_rst_gen", o_gen, 0);
    chk("t6_rst_busy", o_busy, 0);
    chk("t6_rst_phase", o_phase, 0);
    go(2);
    RESET = 1'b1;
    go(2);
    start_burst();
    chk("t6_start", o_start, 1);
    chk("t6_busy", o_busy, 1);
    go(65);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psk_pulse_sequencer.md
Name: psk_pulse_sequencer

Overview:
Timing controller that sequences the PSK synthesis datapath (phase accumulator, ROM, output register) into a burst of radar pulses.
- On a start request it latches pulse width, repetition period, pulse count and phase code.
- It emits per-pulse SIGN_START_CALC / SIGN_STOP_CALC strobes and a gate level.
- It supplies the current 0/180-degree phase-code bit to the phase accumulator.
- It sits between the system configuration registers and the PSK phase accumulator / output register.

Parameters:
CLK_PER_US, 500, clock cycles per microsecond (500 MHz clock); minimum 2.
CODE_W, 32, width of the phase-code register.

Ports:
CLK  in  1  system clock, all logic on rising edge.
RESET  in  1  asynchronous, active-low reset.
SIGN_START_GEN  in  1  start request; rising edge (registered edge detect) arms a burst.
ABORT  in  1  synchronous abort; ends the burst immediately.
T_IMPULSE  in  10  pulse width, us.
T_PERIOD  in  13  pulse repetition period, us, measured start-to-start.
NUM_OF_IMP  in  5  pulses per burst.
PSK_CODE  in  CODE_W  phase code; bit i applies to chip i.
CODE_LEN  in  5  index of last chip used; the code wraps after it.
T_CHIP  in  16  chip duration, clock cycles.
SIGN_START_CALC  out  1  one-cycle strobe on the first cycle of each pulse.
SIGN_STOP_CALC  out  1  one-cycle strobe on the first cycle after each pulse.
GEN_ACTIVE  out  1  high for the whole pulse.
PHASE_FLIP  out  1  current code bit while GEN_ACTIVE, else 0.
IMP_INDEX  out  5  index of the current pulse, 0-based.
BUSY  out  1  high from the first PULSE cycle to the last GAP cycle inclusive.
DONE  out  1  one-cycle strobe when the burst completes normally.
CFG_ERR  out  1  one-cycle strobe when a start is rejected.

Behaviour:
- Reset (RESET=0, asynchronous): every output is 0, state=IDLE, all counters 0, edge-detect register is 0.
- States:
  - IDLE to PULSE on a start edge with valid config.
  - PULSE to GAP after T_IMPULSE us.
  - GAP to PULSE at the period end if pulses remain.
  - GAP to IDLE at the period end after the last pulse.
  - ABORT in PULSE or GAP: to IDLE.
- Start edge: SIGN_START_GEN=1 this cycle and 0 the previous cycle. Edges outside IDLE are ignored, not queued.
- Config check at the edge cycle k. The start is invalid if NUM_OF_IMP=0, T_IMPULSE=0, T_CHIP=0, or T_PERIOD<=T_IMPULSE. Invalid: CFG_ERR=1 at k+1, state stays IDLE. Valid: all inputs are latched at k; later input changes have no effect until the next start.
- Timebase: prescaler pre_cnt counts 0..CLK_PER_US-1; us_cnt increments on prescaler wrap. Both clear at each pulse start.
- Pulse start, cycle s (s=k+1 for the first pulse):
  - SIGN_START_CALC=1 for cycle s only.
  - GEN_ACTIVE=1 for cycles s .. s+T_IMPULSE*CLK_PER_US-1.
  - At s+T_IMPULSE*CLK_PER_US: SIGN_STOP_CALC=1 for one cycle, GEN_ACTIVE=0.
  - Next pulse starts at s+T_PERIOD*CLK_PER_US.
- Pulse counter: IMP_INDEX increments at each subsequent pulse start and holds through GAP.
- Burst end: the last GAP ends at s_last+T_PERIOD*CLK_PER_US-1. DONE=1 on the next cycle, together with IDLE, BUSY=0 and IMP_INDEX=0. A start edge on the DONE cycle is accepted.
- Phase code:
  - chip_idx clears at each pulse start.
  - chip_cnt counts 0..T_CHIP-1; on wrap, chip_idx increments, and goes 0 after reaching CODE_LEN.
  - CODE_LEN>=CODE_W is clamped to CODE_W-1.
  - PHASE_FLIP=PSK_CODE_latched[chip_idx] while GEN_ACTIVE, registered with the same timing as GEN_ACTIVE.
- ABORT:
  - In PULSE: next cycle GEN_ACTIVE=0, PHASE_FLIP=0, SIGN_STOP_CALC=1 for one cycle, IDLE, no DONE.
  - In GAP: next cycle IDLE, no strobes.
  - Ignored in IDLE.
  - ABORT and a start edge together in IDLE: start wins.
- Widths: the us counter is 13 bits and compares against latched T_IMPULSE/T_PERIOD, zero-extended; no overflow is possible. All outputs are registered.
- Reset asserted mid-burst: all outputs go to 0 immediately. No SIGN_STOP_CALC is generated; downstream resets concurrently.

Test Plan:
1. CLK_PER_US=4, T_IMPULSE=2, T_PERIOD=5, NUM_OF_IMP=3, T_CHIP=3 -> start strobes at s, s+20, s+40; GEN_ACTIVE 8 cycles each; stop strobes at s+8, s+28, s+48; IMP_INDEX 0,1,2; DONE at s+60.
2. PSK_CODE=32'b1011, CODE_LEN=3, T_CHIP=2, CLK_PER_US=4, T_IMPULSE=3 -> PHASE_FLIP per 2 cycles: 1,1,0,1 then wraps to 1,1 (12 cycles); restarts at bit 0 on the next pulse.
3. T_PERIOD=2, T_IMPULSE=10 (also NUM_OF_IMP=0; T_CHIP=0) -> CFG_ERR one cycle at k+1, no SIGN_START_CALC, BUSY stays 0.
4. ABORT at the 3rd GEN_ACTIVE cycle of pulse 1 -> next cycle SIGN_STOP_CALC=1, GEN_ACTIVE=0, BUSY=0, no DONE; next start edge is accepted normally.
5. SIGN_START_GEN toggling every 5 cycles during the burst, and T_IMPULSE changed mid-burst -> no restart, timing unchanged; a start edge on the DONE cycle begins a new burst at DONE+1.
6. RESET low mid-pulse -> all outputs 0 immediately, regardless of clock; after release, IDLE and a clean start succeeds.
